// File: rtl/sd_rx.sv
`timescale 1ns/1ps
// sd_rx: receive side of the 74HC595-style seven-segment link. Oversamples stcp/shcp/ds,
// shifts in each frame and decodes every latched frame back into its digit slot.
module sd_rx #(
  parameter int FRAME_BITS  = 14,
  parameter int DIGITS      = 6,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              stcp,
  input  logic              shcp,
  input  logic              ds,
  output logic [3:0]        num6,
  output logic [3:0]        num5,
  output logic [3:0]        num4,
  output logic [3:0]        num3,
  output logic [3:0]        num2,
  output logic [3:0]        num1,
  output logic [DIGITS-1:0] dp,
  output logic [DIGITS-1:0] digit_vld,
  output logic              frame_vld,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);

  logic [2:0]            r_stcp_q;
  logic [2:0]            r_shcp_q;
  logic [2:0]            r_ds_q;
  logic [FRAME_BITS-1:0] r_sreg;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic [3:0]            r_num [DIGITS];
  logic [DIGITS-1:0]     r_dp;
  logic [DIGITS-1:0]     r_vld;
  logic                  r_frame_vld;
  logic                  r_frame_err;

  logic                  w_sh_rise;
  logic                  w_st_rise;
  logic                  w_ds;
  logic [7:0]            w_seg;
  logic [DIGITS-1:0]     w_sel;
  logic [3:0]            w_dec_val;
  logic                  w_dec_ok;
  logic                  w_sel_1hot;
  logic                  w_good;
  logic                  w_bad;

  // Two synchronizer flops plus one delayed copy per line, identical for all three
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_stcp_q <= '0;
      r_shcp_q <= '0;
      r_ds_q   <= '0;
    end else begin
      r_stcp_q <= {r_stcp_q[1:0], stcp};
      r_shcp_q <= {r_shcp_q[1:0], shcp};
      r_ds_q   <= {r_ds_q[1:0], ds};
    end
  end

  assign w_sh_rise = r_shcp_q[1] & ~r_shcp_q[2];
  assign w_st_rise = r_stcp_q[1] & ~r_stcp_q[2];
  // data bit taken from the stage matching shcp's delayed copy (the pre-rise sample)
  assign w_ds      = r_ds_q[2];

  assign w_seg      = r_sreg[FRAME_BITS-1 -: 8];
  assign w_sel      = r_sreg[DIGITS-1:0];
  assign w_sel_1hot = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);

  always_comb begin
    w_dec_ok  = 1'b1;
    w_dec_val = 4'hF;
    case (w_seg[6:0])
      7'h40:   w_dec_val = 4'd0;
      7'h79:   w_dec_val = 4'd1;
      7'h24:   w_dec_val = 4'd2;
      7'h30:   w_dec_val = 4'd3;
      7'h19:   w_dec_val = 4'd4;
      7'h12:   w_dec_val = 4'd5;
      7'h02:   w_dec_val = 4'd6;
      7'h78:   w_dec_val = 4'd7;
      7'h00:   w_dec_val = 4'd8;
      7'h10:   w_dec_val = 4'd9;
      7'h7F:   w_dec_val = 4'hF;
      default: w_dec_ok  = 1'b0;
    endcase
  end

  assign w_good = w_st_rise && (r_bit_cnt == CNT_FRAME) && w_sel_1hot && w_dec_ok;
  assign w_bad  = w_st_rise && !w_good;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg      <= '0;
      r_bit_cnt   <= '0;
      r_frame_vld <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_vld <= w_good;
      r_frame_err <= w_bad;
      if (w_sh_rise) begin
        r_sreg <= {r_sreg[FRAME_BITS-2:0], w_ds};
      end
      // a shift landing with the strobe is the first bit of the next frame
      if (w_st_rise) begin
        r_bit_cnt <= w_sh_rise ? CNT_W'(1) : '0;
      end else if (w_sh_rise && (r_bit_cnt != CNT_SAT)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        r_num[i] <= 4'hF;
      end
      r_dp     <= '0;
      r_vld    <= '0;
      r_to_cnt <= '0;
    end else if (w_good) begin
      r_to_cnt <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        if (w_sel[i]) begin
          r_num[i] <= w_dec_val;
          r_dp[i]  <= ~w_seg[7];
          r_vld[i] <= 1'b1;
        end
      end
    end else if (r_to_cnt == TO_LAST) begin
      r_vld <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  assign num1      = r_num[0];
  assign num2      = r_num[1];
  assign num3      = r_num[2];
  assign num4      = r_num[3];
  assign num5      = r_num[4];
  assign num6      = r_num[5];
  assign dp        = r_dp;
  assign digit_vld = r_vld;
  assign frame_vld = r_frame_vld;
  assign frame_err = r_frame_err;

endmodule
